// File: rtl/fourbitdemux1to2.sv
// Buffered 4-bit 1-to-2 demultiplexer: one valid/ready input steered by sel into
// two independent 2-entry FIFOs, each with its own valid/ready drain and delivery counter.
module fourbitdemux1to2 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2
);

  // Index 0 is channel 1 (sel = 0), index 1 is channel 2 (sel = 1).
  logic [WIDTH-1:0] mem [2][DEPTH];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [1:0]       occ [2];
  logic [7:0]       cnt [2];

  logic [1:0] full;
  logic [1:0] nempty;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] oready;

  always_comb begin
    oready   = {out2_ready, out1_ready};
    full     = '0;
    nempty   = '0;
    pop      = '0;
    for (int c = 0; c < 2; c++) begin
      full[c]   = (occ[c] == 2'(DEPTH));
      nempty[c] = (occ[c] != 2'd0);
      pop[c]    = nempty[c] && oready[c];
    end
    // Ready looks only at the selected FIFO; a full channel stalls input even if the other has room.
    in_ready = !reset && !full[sel];
    push[0]  = in_valid && in_ready && !sel;
    push[1]  = in_valid && in_ready && sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int c = 0; c < 2; c++) begin
        occ[c] <= '0;
        cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wr_ptr[c] <= ~wr_ptr[c];
        if (pop[c]) begin
          rd_ptr[c] <= ~rd_ptr[c];
          cnt[c]    <= cnt[c] + 8'd1;
        end
        if (push[c] && !pop[c])
          occ[c] <= occ[c] + 2'd1;
        else if (!push[c] && pop[c])
          occ[c] <= occ[c] - 2'd1;
      end
    end
  end

  // Storage is data only; emptiness is tracked by occ, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= in_data;
    end
  end

  assign out1_valid = nempty[0];
  assign out2_valid = nempty[1];
  assign out1_data  = nempty[0] ? mem[0][rd_ptr[0]] : '0;
  assign out2_data  = nempty[1] ? mem[1][rd_ptr[1]] : '0;
  assign cnt1       = cnt[0];
  assign cnt2       = cnt[1];

endmodule

// File: tb/tb_fourbitdemux1to2.sv
// Self-checking bench for fourbitdemux1to2: vector table, directed corner sequences
// and a random run, all compared against a queue-based model of the two channels.
module tb_fourbitdemux1to2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [3:0] out2_data;
  logic       out2_valid;
  logic       out2_ready;
  logic [7:0] cnt1;
  logic [7:0] cnt2;

  fourbitdemux1to2 #(.WIDTH(4), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out1_data(out1_data), .out1_valid(out1_valid),
    .out1_ready(out1_ready), .out2_data(out2_data), .out2_valid(out2_valid),
    .out2_ready(out2_ready), .cnt1(cnt1), .cnt2(cnt2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: each channel is a queue of at most two words plus a delivery tally.
  logic [3:0] mq1[$];
  logic [3:0] mq2[$];
  int         mc1 = 0;
  int         mc2 = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    mq1.delete();
    mq2.delete();
    mc1 = 0;
    mc2 = 0;
  endtask

  // Compare DUT against model for the current cycle, advance the model, then clock.
  task automatic step();
    bit er, p1, p2;
    int d1, d2;
    #1;
    er = !reset && ((sel ? mq2.size() : mq1.size()) < 2);
    d1 = 0;
    d2 = 0;
    if (mq1.size() > 0) d1 = mq1[0];
    if (mq2.size() > 0) d2 = mq2[0];
    chk("in_ready", in_ready, er);
    chk("out1_valid", out1_valid, mq1.size() > 0);
    chk("out1_data", out1_data, d1);
    chk("out2_valid", out2_valid, mq2.size() > 0);
    chk("out2_data", out2_data, d2);
    chk("cnt1", cnt1, mc1 % 256);
    chk("cnt2", cnt2, mc2 % 256);
    if (!reset) begin
      p1 = (mq1.size() > 0) && out1_ready;
      p2 = (mq2.size() > 0) && out2_ready;
      if (p1) begin void'(mq1.pop_front()); mc1++; end
      if (p2) begin void'(mq2.pop_front()); mc2++; end
      if (in_valid && er) begin
        if (sel) mq2.push_back(in_data);
        else     mq1.push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       s;
    logic [3:0] d;
    logic       v1;
    logic [3:0] d1;
    logic       v2;
    logic [3:0] d2;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int base;
    vecs[0] = '{s: 1'b0, d: 4'b0101, v1: 1'b1, d1: 4'b0101, v2: 1'b0, d2: 4'b0000};
    vecs[1] = '{s: 1'b1, d: 4'b1010, v1: 1'b0, d1: 4'b0000, v2: 1'b1, d2: 4'b1010};
    vecs[2] = '{s: 1'b0, d: 4'b1111, v1: 1'b1, d1: 4'b1111, v2: 1'b0, d2: 4'b0000};
    vecs[3] = '{s: 1'b1, d: 4'b0000, v1: 1'b0, d1: 4'b0000, v2: 1'b1, d2: 4'b0000};

    reset = 1'b1; in_data = '0; sel = 1'b0; in_valid = 1'b0;
    out1_ready = 1'b0; out2_ready = 1'b0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    step();

    // Routing and latency from the vector table, both readies high.
    out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = vecs[i].s; in_data = vecs[i].d; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
      chk("vec_out1_valid", out1_valid, vecs[i].v1);
      chk("vec_out1_data", out1_data, vecs[i].d1);
      chk("vec_out2_valid", out2_valid, vecs[i].v2);
      chk("vec_out2_data", out2_data, vecs[i].d2);
      step();
    end
    step();
    chk("vec_cnt1", cnt1, 2);
    chk("vec_cnt2", cnt2, 2);

    // Mid-stream async reset with channel 1 holding two words.
    out1_ready = 1'b0; sel = 1'b0; in_valid = 1'b1;
    in_data = 4'h9; step();
    in_data = 4'h6; step();
    in_valid = 1'b0;
    step();
    #2;
    reset = 1'b1;
    mreset();
    #1;
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out1_data", out1_data, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_in_ready", in_ready, 0);
    step();
    reset = 1'b0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_no_stale", out1_valid, 0);
    repeat (3) step();

    // Full channel stalls input even when the other channel has room.
    out1_ready = 1'b0; out2_ready = 1'b0; sel = 1'b0; in_valid = 1'b1;
    in_data = 4'b0001; step();
    in_data = 4'b0010; step();
    in_valid = 1'b0;
    #1;
    chk("stall_sel0_ready", in_ready, 0);
    sel = 1'b1;
    #1;
    chk("stall_sel1_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 4'b0111;
    step();
    in_valid = 1'b0; sel = 1'b0; out1_ready = 1'b1;
    #1;
    chk("full_pop_no_slot", in_ready, 0);
    chk("order_first", out1_data, 4'b0001);
    step();
    #1;
    chk("order_second", out1_data, 4'b0010);
    step();
    out2_ready = 1'b1;
    repeat (2) step();

    // Same-cycle push and pop on channel 2 holding one word.
    out2_ready = 1'b0; sel = 1'b1; in_valid = 1'b1; in_data = 4'h3;
    step();
    base = cnt2;
    out2_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 4'(i + 4);
      #1;
      chk("pp_out2_valid", out2_valid, 1);
      step();
    end
    chk("pp_cnt2", cnt2, (base + 10) % 256);
    in_valid = 1'b0;
    repeat (2) step();

    // Counter wrap: 257 words through channel 1 from a clean reset.
    reset = 1'b1; mreset(); step();
    reset = 1'b0;
    out1_ready = 1'b1; out2_ready = 1'b1; sel = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_data = 4'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    chk("wrap_cnt1", cnt1, 1);
    chk("wrap_cnt2", cnt2, 0);

    // Random traffic against the model.
    for (int i = 0; i < 1000; i++) begin
      sel        = 1'($urandom);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = 4'($urandom);
      out1_ready = ($urandom_range(0, 2) != 0);
      out2_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
    repeat (3) step();
    chk("rand_drained1", out1_valid, 0);
    chk("rand_drained2", out2_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fourbitdemux1to2.md
# fourbitdemux1to2

Buffered 4-bit 1-to-2 demultiplexer: the routing counterpart of the 4-bit 2:1 mux in the Lab4 datapath. It accepts one 4-bit word per valid/ready handshake on a single input channel and steers it, per `sel`, into one of two independent 2-entry output FIFOs, each drained by its own valid/ready handshake. Per-channel delivery counters give the bench a running tally of words delivered on each output.

## Interface
- `WIDTH`, 4: data word width.
- `DEPTH`, 2: entries per output FIFO. Fixed at 2; the pointers are 1 bit and the occupancy counts are 2 bits.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `in_data`  input  WIDTH  word to route.
- `sel`  input  1  0 routes to channel 1, 1 routes to channel 2 (same polarity as the 2:1 mux).
- `in_valid`  input  1  `in_data`/`sel` valid.
- `in_ready`  output  1  the FIFO selected by `sel` can accept a word.
- `out1_data`  output  WIDTH  channel-1 head word.
- `out1_valid`  output  1  channel-1 FIFO non-empty.
- `out1_ready`  input  1  channel-1 consumer accepts.
- `out2_data`  output  WIDTH  channel-2 head word.
- `out2_valid`  output  1  channel-2 FIFO non-empty.
- `out2_ready`  input  1  channel-2 consumer accepts.
- `cnt1`  output  8  words delivered on channel 1, modulo 256.
- `cnt2`  output  8  words delivered on channel 2, modulo 256.

## Operation
- **Input accept:** occurs when `in_valid && in_ready`. The word is written at the selected FIFO's write pointer; that pointer and occupancy advance.
- **`in_ready`:** combinational, equal to NOT full(selected FIFO), forced 0 while `reset` is high. It depends only on `sel`, never on `in_valid`.
- **Full-channel stall:** if the selected FIFO is full, the input stalls. This holds even when the other FIFO has room; there is no reordering or bypass.
- **Output delivery:** occurs when `outN_valid && outN_ready`. The read pointer advances, occupancy decrements and `cntN` increments.
- **Output data:** `outN_data` is the head entry when `outN_valid` is 1, and is forced to 0 when the FIFO is empty.
- **Push and pop, not full:** on the same FIFO in the same cycle, both take effect and occupancy is unchanged.
- **Push when full:** impossible, because `in_ready` is 0. A same-cycle pop on a full FIFO does not open a slot until the next cycle.
- **Channel independence:** the two channels drain independently, and both can deliver in the same cycle.
- **FIFO order:** strict FIFO per channel; word order within a channel is preserved.
- **Counters:** 8-bit, wrapping 255 → 0 with no flag.
- **Per-channel state:** rd_ptr, wr_ptr (1 bit each) and occupancy 0..2.
  - EMPTY (0): `outN_valid` = 0.
  - ONE (1): `outN_valid` = 1; push only → FULL, pop only → EMPTY, push and pop → ONE.
  - FULL (2): blocks input for that channel.
- **Reset (async, any time):**
  - FIFOs are emptied and pointers cleared.
  - `out1_valid` = `out2_valid` = 0, `out1_data` = `out2_data` = 0, `cnt1` = `cnt2` = 0, `in_ready` = 0.
  - In-flight words are discarded.
  - `in_ready` returns to 1 on the first cycle after deassertion.

## Timing
- **Latency:** a word accepted at edge k, into an empty FIFO, gives `outN_valid` = 1 with that word from just after edge k, i.e. visible during cycle k+1.
- **Throughput:** one word per cycle on input; one per cycle per output.
- **Sustained rate:** a channel with `outN_ready` held at 1 sustains 1 word/cycle with occupancy alternating ≤1.
- **Outputs:** `outN_valid`, `outN_data` and `cntN` are registered functions of FIFO state; there is no combinational path from `in_*` to `out*`.
- **Input ready:** `in_ready` is combinational from `sel` and the FIFO state only.
- **Counter update:** `cntN` updates on the edge that completes the delivery handshake.
- **Reset release:** reset deassertion is synchronized by the user; the block only requires it to meet recovery time to `clk`.

## Test plan
- **Reset values:** assert `reset` mid-stream with channel 1 holding 2 words → immediately `out1_valid` = 0, `out1_data` = 0, `cnt1` = 0, `in_ready` = 0; after release, `in_ready` = 1 and no stale word appears.
- **Routing and latency:** `in_data` = 4'b0101, `sel` = 0, then 4'b1010, `sel` = 1, both readies 1 → `out1_data` = 0101 one cycle after the first accept, `out2_data` = 1010 one cycle after the second; `cnt1` = `cnt2` = 1; no cross-talk.
- **Full/stall:** `out1_ready` = 0, push 0001, 0010 on `sel` = 0 → `in_ready` = 0 with `sel` = 0. Switch to `sel` = 1 → `in_ready` = 1 and a push to channel 2 succeeds. Raise `out1_ready` → 0001 then 0010 delivered in order.
- **Simultaneous push and pop:** channel 2 holding 1 word, push and pop in the same cycle repeated 10 cycles → occupancy stays 1, `out2_valid` stays 1, `cnt2` +10, order preserved.
- **Counter wrap:** 257 words through channel 1 → `cnt1` = 1, `cnt2` = 0.
- **Random scoreboard:** 1000 cycles of random `sel`/valid/ready → every input word emerges exactly once on its selected channel, in order, and the counts match the scoreboard.
